mul6_rr_sched: RTL
==================

MUL6_RR_SCHED -- requirements
Module: mul6_rr_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter MUL_LAT, default 7, number of register stages in the attached 6x6 array multiplier.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 req_a, req_b  input  NREQ*6 each  unsigned operands; requester i occupies bits [6i+5:6i].
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  clog2(NREQ)  index of the requester that owns rsp_p.
REQ-011 rsp_p  output  12  unsigned product.
REQ-012 mul_a, mul_b  output  6 each  operands driven to the external multiplier.
REQ-013 mul_p  input  12  multiplier product.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The multiplier reads its operands unregistered at every stage, so mul_a and mul_b shall stay constant from the acceptance edge until mul_p is sampled.
REQ-016 FSM states: IDLE, BUSY, RESP.
REQ-017 In IDLE, when any req_valid bit is set, the block shall assert req_ready combinationally for exactly one granted index g in the same cycle.
REQ-018 Grant selection shall be round-robin: search starts at last_grant+1 mod NREQ, and last_grant updates only on an accepted grant.
REQ-019 On the acceptance edge, the block shall load req_a[g], req_b[g] and g into the operand registers, which drive mul_a, mul_b and the pending id, and shall enter BUSY with cnt=0.
REQ-020 In BUSY, cnt shall increment each cycle; at the edge where cnt==MUL_LAT, the block shall capture mul_p into rsp_p and the id into rsp_id, and shall enter RESP.
REQ-021 Latency: rsp_valid shall rise MUL_LAT+1 rising edges after the acceptance edge (8 with defaults).
REQ-022 In RESP, rsp_valid shall be 1, and rsp_p and rsp_id shall stay stable until rsp_ready=1.
REQ-023 On the RESP handshake edge, the block shall return to IDLE; a new grant is possible only in the following cycle (throughput one operation per MUL_LAT+3 cycles minimum).
REQ-024 req_ready shall be 0 in BUSY and RESP regardless of req_valid.
REQ-025 A requester dropping req_valid while not granted shall be ignored; no request is stored outside the operand registers.
REQ-026 Product width: 12 bits, no truncation; 63*63=3969 is representable.
REQ-027 mul_a and mul_b shall retain their last operands in IDLE and RESP.

Reset
REQ-028 On rst_n low, at any time including mid-BUSY, the block shall asynchronously force state=IDLE, cnt=0, rsp_valid=0, rsp_p=0, rsp_id=0, mul_a=0, mul_b=0, busy=0 and last_grant=NREQ-1, so requester 0 wins first.
REQ-029 An operation in flight at reset shall be discarded and shall produce no response.
REQ-030 The first grant may occur in the first cycle with rst_n high.

Configuration
REQ-031 Macro MUL6_SCHED_ZERO_SKIP_EN: when defined, a grant whose operand a==0 or b==0 shall go IDLE->RESP directly with rsp_p=0 (rsp_valid one edge after acceptance), and mul_a/mul_b shall keep their previous values.
REQ-032 When MUL6_SCHED_ZERO_SKIP_EN is undefined, every grant shall take the full BUSY path, including zero operands.

Structure
REQ-033 Package mul6_sched_pkg shall hold the state enum (IDLE/BUSY/RESP), the operand width 6, the product width 12 and the default MUL_LAT.
REQ-034 Round-robin selection shall be a sub-module mul6_rr_arb (inputs: req vector, last_grant; outputs: one-hot grant, index).
REQ-035 The multiplier shall be instantiated outside this block; this block contains no arithmetic.

Verification
REQ-036 Requester 1 requests a=63, b=63 with rsp_ready=1 -> req_ready[1] in the same cycle, rsp_valid 8 edges later, rsp_p=3969, rsp_id=1.
REQ-037 After reset, requesters 0 and 2 both valid -> grant 0 first, then 2 on the next IDLE; responses 0 then 2.
REQ-038 All 4 requesters continuously valid for 8 operations -> grant order 0,1,2,3,0,1,2,3.
REQ-039 rsp_ready held 0 for 5 cycles in RESP with a=5, b=7 -> rsp_p=35 stable, req_ready all 0, busy=1; the handshake then returns to IDLE.
REQ-040 rst_n pulsed low at BUSY cnt=3 -> all outputs 0 immediately, no response afterwards, and the next grant goes to requester 0.
REQ-041 a=0, b=45 -> rsp_p=0 with rsp_valid 1 edge after acceptance when MUL6_SCHED_ZERO_SKIP_EN is defined, and 8 edges after when it is undefined.

Source files
------------

// File: rtl/mul6_sched_pkg.sv
// Purpose: shared types and widths for the round-robin 6x6 multiplier scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mul6_sched_pkg;

    // Scheduler control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operand and product widths of the attached array multiplier
    localparam int OPW = 6;
    localparam int PW  = 12;

    // Register stages inside the default multiplier build
    localparam int DEF_MUL_LAT = 7;

endpackage

// File: rtl/mul6_rr_arb.sv
// Purpose: round-robin pick of one requester, searching upward from last_grant+1.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
module mul6_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic           found;
    logic [IDW-1:0] cidx;
    int             cand;

    // Walk the requesters in rotating order; the first set bit after last_grant wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(last_grant) + off) % NREQ;
            cidx = IDW'(cand);
            if (!found && req[cidx]) begin
                found     = 1'b1;
                gnt[cidx] = 1'b1;
                idx       = cidx;
            end
        end
    end

endmodule

// File: rtl/mul6_rr_sched.sv
// Purpose: shares one external pipelined 6x6 multiplier among NREQ requesters, round-robin.
// Latency: rsp_valid MUL_LAT+1 edges after the accepting edge (one operation in flight).
// Backpressure: result held in RESP until rsp_ready; no new grant until that handshake.
// Optional build: MUL6_SCHED_ZERO_SKIP_EN short-cuts zero-operand grants straight to RESP.
module mul6_rr_sched
    import mul6_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*OPW-1:0]      req_a,
    input  logic [NREQ*OPW-1:0]      req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [PW-1:0]            rsp_p,
    output logic [OPW-1:0]           mul_a,
    output logic [OPW-1:0]           mul_b,
    input  logic [PW-1:0]            mul_p,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MUL_LAT + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  arb_idx;
    logic [NREQ-1:0] arb_gnt;
    logic [OPW-1:0]  sel_a;
    logic [OPW-1:0]  sel_b;
    logic            accept;
    logic            zero_skip;
    logic            cnt_done;

    mul6_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt        (arb_gnt),
        .idx        (arb_idx)
    );

    // AND-OR mux of the granted requester's operands using the one-hot grant
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_a = sel_a | ({OPW{arb_gnt[i]}} & req_a[i*OPW +: OPW]);
            sel_b = sel_b | ({OPW{arb_gnt[i]}} & req_b[i*OPW +: OPW]);
        end
    end

    // The multiplier output is valid once the operands have been stable for MUL_LAT stages
    assign cnt_done = (cnt == CW'(MUL_LAT));

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and grant decode; req_ready can only be non-zero while IDLE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        zero_skip = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    accept    = 1'b1;
                    req_ready = arb_gnt;
`ifdef MUL6_SCHED_ZERO_SKIP_EN
                    if ((sel_a == '0) || (sel_b == '0)) begin
                        zero_skip = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = BUSY;
                    end
`else
                    state_nxt = BUSY;
`endif
                end
            end
            BUSY: begin
                if (cnt_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand hold, latency count and result capture; operands only change on a real grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            last_grant <= IDW'(NREQ - 1);
            id_q       <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_p      <= '0;
            rsp_id     <= '0;
        end else begin
            if (accept) begin
                last_grant <= arb_idx;
                id_q       <= arb_idx;
                cnt        <= '0;
                if (zero_skip) begin
                    rsp_p  <= '0;
                    rsp_id <= arb_idx;
                end else begin
                    mul_a <= sel_a;
                    mul_b <= sel_b;
                end
            end else if (state == BUSY) begin
                if (cnt_done) begin
                    rsp_p  <= mul_p;
                    rsp_id <= id_q;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    // Status outputs decoded from the state register
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule
